branch_pred: RTL and testbench
==============================

BRANCH_PRED -- requirements
Module: branch_pred

Interface
REQ-001 SHALL have parameter PC_W, default 32: PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 16: BHT/BTB depth, power of two >= 4; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter TAG_W, default 8: BTB tag width.
REQ-004 SHALL have parameter CNT_W, default 2: saturating-counter width, 1..4.
REQ-005 SHALL have parameter MODE, default 1: 0 static not-taken, 1 bimodal, 2 gshare.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port lk_pc, input, PC_W bits: fetch PC to predict.
REQ-009 SHALL have port lk_taken, output, 1 bit: predicted taken.
REQ-010 SHALL have port lk_target, output, PC_W bits: predicted target, 0 when lk_taken=0.
REQ-011 SHALL have port up_valid, input, 1 bit: resolved-branch update strobe from EX.
REQ-012 SHALL have port up_pc, input, PC_W bits: PC of the resolved branch.
REQ-013 SHALL have port up_taken, input, 1 bit: actual outcome.
REQ-014 SHALL have port up_target, input, PC_W bits: actual target.
REQ-015 SHALL have port up_mispred, input, 1 bit: prediction was wrong; qualified by up_valid.
REQ-016 SHALL have port tbl_clr, input, 1 bit: synchronous clear of all state.
REQ-017 SHALL have port mis_cnt, output, 16 bits: saturating mispredict counter.
REQ-018 SHALL have port upd_cnt, output, 16 bits: saturating update counter.

Function
REQ-019 SHALL form the index bimodal as pc[IDX_W+1:2], and gshare as pc[IDX_W+1:2] XOR ghr[IDX_W-1:0]; BTB always indexes with pc[IDX_W+1:2].
REQ-020 SHALL take the tag from pc[TAG_W+IDX_W+1:IDX_W+2].
REQ-021 SHALL drive lk_taken combinationally as: BTB entry valid, tag match, and counter MSB = 1; MODE 0 SHALL force lk_taken = 0.
REQ-022 SHALL read lk_* from registered state only, so the update written at edge N is first visible to lookup in the cycle after edge N.
REQ-023 SHALL, on up_valid at a clock edge, increment the counter at the update index when up_taken = 1 and decrement it otherwise, saturating at 0 and 2^CNT_W-1.
REQ-024 SHALL, on up_valid with up_taken = 1, write the BTB entry as valid=1, tag, and target=up_target; up_taken = 0 SHALL leave the BTB unchanged.
REQ-025 SHALL, in MODE 2, shift ghr left by one with up_taken in the LSB on each up_valid (non-speculative, IDX_W bits); the index for that update SHALL use ghr before the shift.
REQ-026 SHALL increment upd_cnt on each up_valid and mis_cnt on up_valid & up_mispred, both saturating at 16'hFFFF.
REQ-027 SHALL give tbl_clr priority over a simultaneous up_valid: all valid bits cleared, counters to weakly-not-taken (2^(CNT_W-1)-1), ghr=0, perf counters=0.
REQ-028 SHALL, when lookup and update hit the same entry in one cycle, serve the lookup the pre-update value.

Reset
REQ-029 SHALL, on rst low, immediately (asynchronously) clear all BTB valid bits, tags and targets to 0, all counters to weakly-not-taken, ghr=0 and mis_cnt=upd_cnt=0, giving outputs lk_taken=0, lk_target=0, mis_cnt=0 and upd_cnt=0.
REQ-030 SHALL ignore up_valid while rst is low, and an update coincident with reset deassertion SHALL NOT be lost: the first rising edge with rst high samples normally.

Structure
REQ-031 SHALL place the MODE encodings (STATIC, BIMODAL, GSHARE) and the counter-reset-value function in the shared cpu package.
REQ-032 SHALL implement the saturating counter table as one sub-module, sat_cnt_table (ENTRIES x CNT_W, one read port, one write port); the BTB stays inline.

Verification
REQ-033 SHALL verify reset: release rst, lookup lk_pc=0x40 -> lk_taken=0, lk_target=0, mis_cnt=0.
REQ-034 SHALL verify bimodal training (MODE=1, CNT_W=2): two updates pc=0x40, taken, target=0x80 -> the lookup of 0x40 on the next cycle gives lk_taken=1, lk_target=0x80; one more not-taken update keeps it taken (counter 2).
REQ-035 SHALL verify aliasing: after training 0x40, look up 0x40 + (ENTRIES*4) (same index, different tag) -> lk_taken=0.
REQ-036 SHALL verify saturation: 5 taken updates then 3 not-taken updates at one PC -> counter=0, lk_taken=0; 70000 mispredicted updates -> mis_cnt=0xFFFF.
REQ-037 SHALL verify gshare (MODE=2): an alternating T/N branch at 0x100, after 8 updates -> the prediction matches the next outcome on each of the following 4 lookups.
REQ-038 SHALL verify tbl_clr and up_valid asserted in the same cycle -> all state cleared, upd_cnt=0, and lookup of a trained PC gives lk_taken=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: predictor mode encodings and counter helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    STATIC  = 2'd0,
    BIMODAL = 2'd1,
    GSHARE  = 2'd2
  } pred_mode_e;

  // Weakly-not-taken value for a saturating counter of the given width.
  function automatic int cnt_rst_val(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_cnt_table.sv
// Table of saturating up/down counters: one combinational read port, one
// read-modify-write port that steps the addressed counter toward taken/not-taken.
module sat_cnt_table
  import cpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_inc
);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_rst_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] wr_cur;
  logic [CNT_W-1:0] wr_nxt;

  // Reads come straight from the registers, so a same-cycle write is not seen.
  assign rd_cnt = cnt_q[rd_idx];
  assign wr_cur = cnt_q[wr_idx];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_nxt = wr_cur;
    if (wr_inc && (wr_cur != CNT_MAX)) begin
      wr_nxt = wr_cur + CNT_W'(1);
    end else if (!wr_inc && (wr_cur != '0)) begin
      wr_nxt = wr_cur - CNT_W'(1);
    end
  end

  // NOTE: this table is flops, not SRAM, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_nxt;
    end
  end

endmodule

// File: rtl/branch_pred.sv
// Branch predictor: direct-mapped tagged BTB plus a static/bimodal/gshare
// direction table, trained non-speculatively from resolved branches.
module branch_pred
  import cpu_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_target,
  input  logic            up_valid,
  input  logic [PC_W-1:0] up_pc,
  input  logic            up_taken,
  input  logic [PC_W-1:0] up_target,
  input  logic            up_mispred,
  input  logic            tbl_clr,
  output logic [15:0]     mis_cnt,
  output logic [15:0]     upd_cnt
);

  localparam int IDX_W     = $clog2(ENTRIES);
  localparam bit IS_STATIC = (MODE == int'(STATIC));
  localparam bit IS_GSHARE = (MODE == int'(GSHARE));

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [PC_W-1:0]    btb_target [ENTRIES];
  logic [IDX_W-1:0]   ghr;

  logic [IDX_W-1:0] lk_bidx, lk_cidx, up_bidx, up_cidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [CNT_W-1:0] lk_cnt;
  logic             lk_hit;
  logic             unused_pc_bits;

  assign lk_bidx = lk_pc[IDX_W+1:2];
  assign up_bidx = up_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign up_tag  = up_pc[TAG_W+IDX_W+1:IDX_W+2];

  // gshare hashes with the history as it stood before this update shifts it.
  assign lk_cidx = IS_GSHARE ? (lk_bidx ^ ghr) : lk_bidx;
  assign up_cidx = IS_GSHARE ? (up_bidx ^ ghr) : up_bidx;

  assign unused_pc_bits = ^{lk_pc, up_pc};

  sat_cnt_table #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (tbl_clr),
    .rd_idx (lk_cidx),
    .rd_cnt (lk_cnt),
    .wr_en  (up_valid),
    .wr_idx (up_cidx),
    .wr_inc (up_taken)
  );

  assign lk_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
  assign lk_taken  = !IS_STATIC && lk_hit && lk_cnt[CNT_W-1];
  assign lk_target = lk_taken ? btb_target[lk_bidx] : '0;

  // Not-taken outcomes leave the BTB alone so a known target survives them.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (tbl_clr) begin
      btb_valid <= '0;
    end else if (up_valid && up_taken) begin
      btb_valid[up_bidx]  <= 1'b1;
      btb_tag[up_bidx]    <= up_tag;
      btb_target[up_bidx] <= up_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr     <= '0;
      mis_cnt <= '0;
      upd_cnt <= '0;
    end else if (tbl_clr) begin
      ghr     <= '0;
      mis_cnt <= '0;
      upd_cnt <= '0;
    end else if (up_valid) begin
      if (IS_GSHARE) ghr <= {ghr[IDX_W-2:0], up_taken};
      if (upd_cnt != 16'hFFFF) upd_cnt <= upd_cnt + 16'd1;
      if (up_mispred && (mis_cnt != 16'hFFFF)) mis_cnt <= mis_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_pred.sv
// Directed bench for branch_pred: bimodal, gshare and static instances share
// one stimulus stream; expected values are hand-derived constants.
module tb_branch_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc;
  logic        up_valid, up_taken, up_mispred, tbl_clr;
  logic [31:0] up_pc, up_target;

  logic        tk_b, tk_g, tk_s;
  logic [31:0] tg_b, tg_g, tg_s;
  logic [15:0] mis_b, mis_g, mis_s, upd_b, upd_g, upd_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_pred #(.MODE(1)) u_bim (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(tk_b), .lk_target(tg_b),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
    .up_mispred(up_mispred), .tbl_clr(tbl_clr), .mis_cnt(mis_b), .upd_cnt(upd_b)
  );

  branch_pred #(.MODE(2)) u_gsh (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(tk_g), .lk_target(tg_g),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
    .up_mispred(up_mispred), .tbl_clr(tbl_clr), .mis_cnt(mis_g), .upd_cnt(upd_g)
  );

  branch_pred #(.MODE(0)) u_sta (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(tk_s), .lk_target(tg_s),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
    .up_mispred(up_mispred), .tbl_clr(tbl_clr), .mis_cnt(mis_s), .upd_cnt(upd_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One update strobe covering exactly one rising edge, negedge to negedge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    @(negedge clk);
    up_valid = 1'b1; up_pc = pc; up_taken = tk; up_target = tgt; up_mispred = mis;
    @(negedge clk);
    up_valid = 1'b0; up_mispred = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lk_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b0; tbl_clr = 1'b0; lk_pc = 32'h40;
    up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_target = 32'h80; up_mispred = 1'b1;
    #1;
    check("rst_lk_taken", {31'd0, tk_b}, 32'd0);
    check("rst_lk_target", tg_b, 32'd0);
    check("rst_mis_cnt", {16'd0, mis_b}, 32'd0);
    check("rst_upd_cnt", {16'd0, upd_b}, 32'd0);

    // Two edges pass with rst low and an update pending; then release with a
    // not-taken update at 0x24 that must land on the first edge.
    @(negedge clk); @(negedge clk);
    rst = 1'b1; up_pc = 32'h24; up_taken = 1'b0; up_target = 32'h0; up_mispred = 1'b0;
    @(negedge clk);
    up_valid = 1'b0;
    look(32'h40);
    check("rel_upd_cnt", {16'd0, upd_b}, 32'd1);
    check("rel_mis_cnt", {16'd0, mis_b}, 32'd0);
    check("rel_lk_taken", {31'd0, tk_b}, 32'd0);
    check("rel_lk_target", tg_b, 32'd0);

    // Bimodal training: counter 1 -> 2 -> 3, then one not-taken -> 2.
    upd(32'h40, 1'b1, 32'h80, 1'b1);
    upd(32'h40, 1'b1, 32'h80, 1'b0);
    look(32'h40);
    check("bim_taken", {31'd0, tk_b}, 32'd1);
    check("bim_target", tg_b, 32'h80);
    check("static_taken", {31'd0, tk_s}, 32'd0);
    check("static_target", tg_s, 32'd0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    check("bim_hyst_taken", {31'd0, tk_b}, 32'd1);
    check("bim_hyst_target", tg_b, 32'h80);

    // Same index, different tag.
    look(32'h40 + 32'd64);
    check("alias_taken", {31'd0, tk_b}, 32'd0);
    check("alias_target", tg_b, 32'd0);

    // Lookup and update hitting one entry: lookup sees the pre-update counter.
    @(negedge clk);
    up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b0; up_mispred = 1'b0;
    look(32'h40);
    check("bypass_pre", {31'd0, tk_b}, 32'd1);
    @(negedge clk);
    up_valid = 1'b0;
    look(32'h40);
    check("bypass_post", {31'd0, tk_b}, 32'd0);

    // Saturation at 0x48: 5 taken -> 3, 3 not-taken -> 0, then 0 -> 1 -> 2.
    for (int i = 0; i < 5; i++) upd(32'h48, 1'b1, 32'hC0, 1'b0);
    look(32'h48);
    check("sat_hi_taken", {31'd0, tk_b}, 32'd1);
    check("sat_hi_target", tg_b, 32'hC0);
    for (int i = 0; i < 3; i++) upd(32'h48, 1'b0, 32'h0, 1'b0);
    look(32'h48);
    check("sat_lo_taken", {31'd0, tk_b}, 32'd0);
    upd(32'h48, 1'b1, 32'hC0, 1'b0);
    look(32'h48);
    check("sat_lo_plus1", {31'd0, tk_b}, 32'd0);
    upd(32'h48, 1'b1, 32'hC0, 1'b0);
    look(32'h48);
    check("sat_lo_plus2", {31'd0, tk_b}, 32'd1);
    check("upd_cnt_15", {16'd0, upd_b}, 32'd15);
    check("mis_cnt_1", {16'd0, mis_b}, 32'd1);

    // 70000 back-to-back mispredicted updates saturate both perf counters.
    @(negedge clk);
    up_valid = 1'b1; up_pc = 32'h24; up_taken = 1'b0; up_mispred = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    up_valid = 1'b0; up_mispred = 1'b0;
    @(negedge clk);
    check("mis_cnt_sat", {16'd0, mis_b}, 32'hFFFF);
    check("upd_cnt_sat", {16'd0, upd_b}, 32'hFFFF);
    check("static_mis_sat", {16'd0, mis_s}, 32'hFFFF);
    check("static_upd_sat", {16'd0, upd_s}, 32'hFFFF);

    // Clear wins over a simultaneous taken update.
    look(32'h48);
    check("pre_clr_taken", {31'd0, tk_b}, 32'd1);
    @(negedge clk);
    tbl_clr = 1'b1; up_valid = 1'b1; up_pc = 32'h48; up_taken = 1'b1;
    up_target = 32'hC0; up_mispred = 1'b1;
    @(negedge clk);
    tbl_clr = 1'b0; up_valid = 1'b0; up_mispred = 1'b0;
    look(32'h48);
    check("clr_taken_48", {31'd0, tk_b}, 32'd0);
    check("clr_upd_cnt", {16'd0, upd_b}, 32'd0);
    check("clr_mis_cnt", {16'd0, mis_b}, 32'd0);
    look(32'h40);
    check("clr_taken_40", {31'd0, tk_b}, 32'd0);

    // gshare: alternating T/N at 0x100 (starting T). After 8 updates ghr=1010
    // and the history-hashed entries predict the alternation exactly.
    for (int i = 0; i < 8; i++) upd(32'h100, (i % 2) == 0, 32'h180, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic exp_tk;
      exp_tk = ((k % 2) == 0);
      look(32'h100);
      check($sformatf("gsh_taken_%0d", k), {31'd0, tk_g}, {31'd0, exp_tk});
      check($sformatf("gsh_target_%0d", k), tg_g, exp_tk ? 32'h180 : 32'h0);
      upd(32'h100, exp_tk, 32'h180, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
